systolic_mac_pe: RTL and testbench
==================================

// Module: systolic_mac_pe
// PURPOSE
//  Next-gen processing element for the output-stationary systolic matmul array.
//  - Valid-tagged operands flow west->east and north->south.
//  - first/last tags bound each dot product; completed results are saturated and buffered.
//  - Results are shifted south over a ready/valid drain chain with backpressure.
//  - Optional multiply pipeline stage for timing closure.
// PARAMETERS
//  BW       16  signed operand width
//  ACCW     40  accumulator width (must be >= 2*BW); wraps modulo 2^ACCW
//  OUTW     32  drained result width (must be <= ACCW)
//  MUL_PIPE 1   0: combinational multiply; 1: registered product plus tags
//  SAT_OUT  1   1: saturate acc to signed OUTW; 0: truncate to acc[OUTW-1:0]
// PORTS
//  clk             in   1     clock
//  rst             in   1     asynchronous, active-high reset
//  in_west_data    in   BW    signed A operand
//  in_west_valid   in   1     A operand valid
//  in_west_first   in   1     beat starts a new dot product (qualified by fire)
//  in_west_last    in   1     beat ends the dot product (qualified by fire)
//  in_north_data   in   BW    signed B operand
//  in_north_valid  in   1     B operand valid
//  out_east_*      out  BW/1  registered copies of in_west_{data,valid,first,last}
//  out_south_*     out  BW/1  registered copies of in_north_{data,valid}
//  drain_in_data   in   OUTW  result from PE above
//  drain_in_valid  in   1     upstream result valid
//  drain_in_ready  out  1     this PE accepts the upstream result
//  drain_out_data  out  OUTW  result to PE below
//  drain_out_valid out  1     drain_out_data valid
//  drain_out_ready in   1     downstream accepts
//  clr_err         in   1     synchronous clear of err_overflow
//  err_overflow    out  1     sticky: a completed result was dropped
// BEHAVIOUR
//  - Reset: every register and output is 0, including acc, product stage, res_q, drain_out and err.
//    Reset mid-operation discards partial sums and buffered results.
//  - Forwarding: east/south outputs = inputs delayed 1 cycle, always, independent of the drain chain.
//  - fire = in_west_valid & in_north_valid. No fire: no MAC, and first/last are ignored.
//  - Product: 2*BW-bit signed, sign-extended to ACCW.
//    MUL_PIPE=1 registers {prod, fire, first, last}; accumulate stage uses the registered copy.
//  - Accumulate stage, on a tagged fire:
//    acc <= first ? prod : acc + prod.
//    If last: res_q <= sat(first ? prod : acc + prod); res_valid <= 1.
//  - sat(): SAT_OUT=1 clamps to [-2^(OUTW-1), 2^(OUTW-1)-1]; otherwise truncates.
//  - Latency: fire beat with last -> res_valid at edge 1+MUL_PIPE;
//    -> drain_out_valid 1 cycle later if the output slot is free.
//  - Output slot (drain_out) is free when drain_out_valid=0 or drain_out_ready=1.
//    When free, load priority:
//      1. res_q, if res_valid (this clears res_valid unless a new result lands the same edge)
//      2. drain_in, if drain_in_valid & drain_in_ready
//    If nothing loads, drain_out_valid <= 0.
//  - drain_in_ready = slot free & ~res_valid (combinational from drain_out_ready).
//  - drain_out_data/valid hold stable while valid & ~ready.
//  - Overflow: a new result arrives while res_valid=1 and res_q is not moving this edge
//    -> new result dropped, res_q kept, err_overflow <= 1.
//    err_overflow clears only on rst or clr_err. If clr_err and a new overflow coincide, set wins.
//  - A first without a preceding last restarts acc silently. A last with no first in the
//    current run accumulates onto the existing acc.
// TESTING
//  T1 MUL_PIPE=0: W=(3,-4,5), N=(2,6,-1), first@beat0, last@beat2
//     -> drain_out_data=-23 (0xFFFFFFE9), valid 2 cycles after beat2.
//  T2 OUTW=16: single beat first&last, 32767*32767
//     -> SAT_OUT=1: 0x7FFF; SAT_OUT=0: 0x0001. Same test with -32768*32767, SAT_OUT=1 -> 0x8000.
//  T3 in_north_valid only, in_north_data=0x1234
//     -> out_south_data=0x1234, valid next cycle; acc unchanged; no result produced.
//  T4 drain_out_ready=0, three 1-beat results 7, 8, 9
//     -> 7 held in drain_out, 8 in res_q, 9 dropped, err_overflow=1;
//     ready=1 -> 7 then 8 emitted; clr_err -> err_overflow=0.
//  T5 res_valid (value 5) and drain_in_valid (value 11) in the same cycle, ready=1
//     -> 5 emitted first with drain_in_ready=0; 11 emitted next cycle.
//  T6 rst asserted between first and last beats
//     -> all outputs 0; after release, a lone last beat 2*3 -> result 6.

Source files
------------

// File: rtl/systolic_mac_pe_if.sv
// Port bundle of one systolic MAC processing element: operand forwarding,
// drain chain and error status. The PE takes the slave side.
interface systolic_mac_pe_if #(
   parameter int BW   = 16,
   parameter int OUTW = 32
);
   logic [BW-1:0]   in_west_data;
   logic            in_west_valid;
   logic            in_west_first;
   logic            in_west_last;
   logic [BW-1:0]   in_north_data;
   logic            in_north_valid;
   logic [BW-1:0]   out_east_data;
   logic            out_east_valid;
   logic            out_east_first;
   logic            out_east_last;
   logic [BW-1:0]   out_south_data;
   logic            out_south_valid;
   logic [OUTW-1:0] drain_in_data;
   logic            drain_in_valid;
   logic            drain_in_ready;
   logic [OUTW-1:0] drain_out_data;
   logic            drain_out_valid;
   logic            drain_out_ready;
   logic            clr_err;
   logic            err_overflow;

   modport slave (
      input  in_west_data, in_west_valid, in_west_first, in_west_last,
      input  in_north_data, in_north_valid,
      input  drain_in_data, drain_in_valid, drain_out_ready, clr_err,
      output out_east_data, out_east_valid, out_east_first, out_east_last,
      output out_south_data, out_south_valid,
      output drain_in_ready, drain_out_data, drain_out_valid, err_overflow
   );

   modport master (
      output in_west_data, in_west_valid, in_west_first, in_west_last,
      output in_north_data, in_north_valid,
      output drain_in_data, drain_in_valid, drain_out_ready, clr_err,
      input  out_east_data, out_east_valid, out_east_first, out_east_last,
      input  out_south_data, out_south_valid,
      input  drain_in_ready, drain_out_data, drain_out_valid, err_overflow
   );
endinterface

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC PE: forwards operands east/south, accumulates
// tagged dot products, and shifts saturated results down a ready/valid drain chain.
module systolic_mac_pe #(
   parameter int BW       = 16,
   parameter int ACCW     = 40,
   parameter int OUTW     = 32,
   parameter int MUL_PIPE = 1,
   parameter int SAT_OUT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   systolic_mac_pe_if.slave   pe
);
   localparam int PW     = 2 * BW;
   localparam int STAGES = (MUL_PIPE != 0) ? 1 : 0;

   typedef struct packed {
      logic [PW-1:0] prod;
      logic          first;
      logic          last;
   } mac_op_t;

   logic              fire;
   mac_op_t           op_c, op_s;
   logic [STAGES:0]   vld_pipe;
   logic              s_fire;

   logic signed [ACCW-1:0] acc, prod_x, sum;
   logic [OUTW-1:0]   res_q, dout_q;
   logic              res_valid, dout_v, err_q;
   logic              slot_free, res_move, new_res, ovf;

   function automatic logic [OUTW-1:0] sat(input logic signed [ACCW-1:0] v);
      // Value fits in signed OUTW when all bits from OUTW-1 upward match the sign.
      if (SAT_OUT == 0 || v[ACCW-1:OUTW-1] == {(ACCW-OUTW+1){v[ACCW-1]}})
         return v[OUTW-1:0];
      else if (v[ACCW-1])
         return {1'b1, {(OUTW-1){1'b0}}};
      else
         return {1'b0, {(OUTW-1){1'b1}}};
   endfunction

   // ---------------- operand forwarding ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pe.out_east_data   <= '0;
         pe.out_east_valid  <= 1'b0;
         pe.out_east_first  <= 1'b0;
         pe.out_east_last   <= 1'b0;
         pe.out_south_data  <= '0;
         pe.out_south_valid <= 1'b0;
      end else begin
         pe.out_east_data   <= pe.in_west_data;
         pe.out_east_valid  <= pe.in_west_valid;
         pe.out_east_first  <= pe.in_west_first;
         pe.out_east_last   <= pe.in_west_last;
         pe.out_south_data  <= pe.in_north_data;
         pe.out_south_valid <= pe.in_north_valid;
      end
   end

   // ---------------- multiply (optionally registered) ----------------
   assign fire       = pe.in_west_valid & pe.in_north_valid;
   assign op_c.prod  = PW'($signed(pe.in_west_data)) * PW'($signed(pe.in_north_data));
   assign op_c.first = pe.in_west_first;
   assign op_c.last  = pe.in_west_last;

   generate
      if (STAGES == 1) begin : g_pipe
         mac_op_t op_q;
         logic    vld_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               op_q  <= '0;
               vld_q <= 1'b0;
            end else begin
               vld_q <= vld_pipe[0];
               if (vld_pipe[0]) op_q <= op_c;
            end
         end
         assign vld_pipe = {vld_q, fire};
         assign op_s     = op_q;
      end else begin : g_comb
         assign vld_pipe = fire;
         assign op_s     = op_c;
      end
   endgenerate

   assign s_fire = vld_pipe[STAGES];

   // ---------------- accumulate ----------------
   assign prod_x  = ACCW'($signed(op_s.prod));
   assign sum     = op_s.first ? prod_x : acc + prod_x;
   assign new_res = s_fire & op_s.last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         acc <= '0;
      else if (s_fire) acc <= sum;
   end

   // ---------------- result buffer and drain chain ----------------
   assign slot_free         = ~dout_v | pe.drain_out_ready;
   assign res_move          = slot_free & res_valid;
   // A result landing while res_q is stuck has nowhere to go and is dropped.
   assign ovf               = new_res & res_valid & ~res_move;
   assign pe.drain_in_ready = slot_free & ~res_valid;
   assign pe.drain_out_data  = dout_q;
   assign pe.drain_out_valid = dout_v;
   assign pe.err_overflow    = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q     <= '0;
         res_valid <= 1'b0;
      end else if (new_res && !ovf) begin
         res_q     <= sat(sum);
         res_valid <= 1'b1;
      end else if (res_move) begin
         res_valid <= 1'b0;
      end
   end

   // Local result takes the slot ahead of upstream traffic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
         dout_v <= 1'b0;
      end else if (slot_free) begin
         if (res_valid) begin
            dout_q <= res_q;
            dout_v <= 1'b1;
         end else if (pe.drain_in_valid) begin
            dout_q <= pe.drain_in_data;
            dout_v <= 1'b1;
         end else begin
            dout_v <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             err_q <= 1'b0;
      else if (ovf)        err_q <= 1'b1;
      else if (pe.clr_err) err_q <= 1'b0;
   end
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: three PEs (32-bit comb multiply, 16-bit saturating and
// 16-bit truncating with registered multiply) share operand stimulus; scoreboards per PE.
module tb_systolic_mac_pe;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] w_data, n_data;
   logic        w_valid, w_first, w_last, n_valid;
   logic [31:0] din_data;
   logic        din_valid, rdy0, clr0;

   systolic_mac_pe_if #(.BW(16), .OUTW(32)) b0();
   systolic_mac_pe_if #(.BW(16), .OUTW(16)) bs();
   systolic_mac_pe_if #(.BW(16), .OUTW(16)) bt();

   assign b0.in_west_data    = w_data;
   assign b0.in_west_valid   = w_valid;
   assign b0.in_west_first   = w_first;
   assign b0.in_west_last    = w_last;
   assign b0.in_north_data   = n_data;
   assign b0.in_north_valid  = n_valid;
   assign b0.drain_in_data   = din_data;
   assign b0.drain_in_valid  = din_valid;
   assign b0.drain_out_ready = rdy0;
   assign b0.clr_err         = clr0;

   assign bs.in_west_data    = w_data;
   assign bs.in_west_valid   = w_valid;
   assign bs.in_west_first   = w_first;
   assign bs.in_west_last    = w_last;
   assign bs.in_north_data   = n_data;
   assign bs.in_north_valid  = n_valid;
   assign bs.drain_in_data   = 16'h0;
   assign bs.drain_in_valid  = 1'b0;
   assign bs.drain_out_ready = 1'b1;
   assign bs.clr_err         = 1'b0;

   assign bt.in_west_data    = w_data;
   assign bt.in_west_valid   = w_valid;
   assign bt.in_west_first   = w_first;
   assign bt.in_west_last    = w_last;
   assign bt.in_north_data   = n_data;
   assign bt.in_north_valid  = n_valid;
   assign bt.drain_in_data   = 16'h0;
   assign bt.drain_in_valid  = 1'b0;
   assign bt.drain_out_ready = 1'b1;
   assign bt.clr_err         = 1'b0;

   systolic_mac_pe #(.BW(16), .ACCW(40), .OUTW(32), .MUL_PIPE(0), .SAT_OUT(1))
      dut0 (.clk(clk), .rst(rst), .pe(b0));
   systolic_mac_pe #(.BW(16), .ACCW(40), .OUTW(16), .MUL_PIPE(1), .SAT_OUT(1))
      dut_s (.clk(clk), .rst(rst), .pe(bs));
   systolic_mac_pe #(.BW(16), .ACCW(40), .OUTW(16), .MUL_PIPE(1), .SAT_OUT(0))
      dut_t (.clk(clk), .rst(rst), .pe(bt));

   int          n_tests = 0;
   int          n_fail  = 0;
   longint      macc    = 0;
   logic [31:0] q0[$];
   logic [15:0] qs[$], qt[$];
   logic [31:0] e0;
   logic [15:0] es, et;

   function automatic longint clampw(input longint v, input int w);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic push_res(input longint v, input bit to0);
      logic [63:0] c32, c16, raw;
      c32 = clampw(v, 32);
      c16 = clampw(v, 16);
      raw = v;
      if (to0) q0.push_back(c32[31:0]);
      qs.push_back(c16[15:0]);
      qt.push_back(raw[15:0]);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One tagged fire beat; the model accumulates and queues completed results.
   task automatic beat(input int a, input int b, input bit f, input bit l, input bit to0);
      longint p;
      p = longint'(a) * longint'(b);
      macc = f ? p : macc + p;
      if (l) push_res(macc, to0);
      w_data = a[15:0]; n_data = b[15:0];
      w_valid = 1'b1; n_valid = 1'b1; w_first = f; w_last = l;
      tick();
      w_valid = 1'b0; n_valid = 1'b0; w_first = 1'b0; w_last = 1'b0;
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (!rst && b0.drain_out_valid && b0.drain_out_ready) begin
         n_tests = n_tests + 1;
         if (q0.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain0_unexpected got=%h", b0.drain_out_data);
         end else begin
            e0 = q0.pop_front();
            if (b0.drain_out_data !== e0) begin
               n_fail = n_fail + 1;
               $display("FAIL drain0_data got=%h exp=%h", b0.drain_out_data, e0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bs.drain_out_valid) begin
         n_tests = n_tests + 1;
         if (qs.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain_sat_unexpected got=%h", bs.drain_out_data);
         end else begin
            es = qs.pop_front();
            if (bs.drain_out_data !== es) begin
               n_fail = n_fail + 1;
               $display("FAIL drain_sat_data got=%h exp=%h", bs.drain_out_data, es);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bt.drain_out_valid) begin
         n_tests = n_tests + 1;
         if (qt.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain_trunc_unexpected got=%h", bt.drain_out_data);
         end else begin
            et = qt.pop_front();
            if (bt.drain_out_data !== et) begin
               n_fail = n_fail + 1;
               $display("FAIL drain_trunc_data got=%h exp=%h", bt.drain_out_data, et);
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b0 || b0.drain_out_data !== 32'h0 ||
          b0.err_overflow !== 1'b0 || b0.out_east_valid !== 1'b0 ||
          b0.out_south_valid !== 1'b0 || bs.drain_out_valid !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_state got v=%b d=%h e=%b ev=%b sv=%b exp all 0",
                  b0.drain_out_valid, b0.drain_out_data, b0.err_overflow,
                  b0.out_east_valid, b0.out_south_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_dot();
      beat(3, 2, 1'b1, 1'b0, 1'b1);
      beat(-4, 6, 1'b0, 1'b0, 1'b1);
      beat(5, -1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL dot_latency_early got valid=%b exp 0", b0.drain_out_valid);
      end
      tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b1 || b0.drain_out_data !== 32'hFFFF_FFE9) begin
         n_fail = n_fail + 1;
         $display("FAIL dot_result got valid=%b data=%h exp 1/ffffffe9",
                  b0.drain_out_valid, b0.drain_out_data);
      end
      repeat (4) tick();
   endtask

   task automatic test_sat();
      beat(32767, 32767, 1'b1, 1'b1, 1'b1);
      tick(); tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (bs.drain_out_data !== 16'h7FFF || bt.drain_out_data !== 16'h0001) begin
         n_fail = n_fail + 1;
         $display("FAIL sat_pos16 got sat=%h trunc=%h exp 7fff/0001",
                  bs.drain_out_data, bt.drain_out_data);
      end
      repeat (3) tick();
      beat(-32768, 32767, 1'b1, 1'b1, 1'b1);
      repeat (4) tick();
      beat(-32768, -32768, 1'b1, 1'b0, 1'b1);
      beat(-32768, -32768, 1'b0, 1'b1, 1'b1);
      repeat (5) tick();
   endtask

   task automatic test_forward();
      beat(2, 5, 1'b1, 1'b0, 1'b1);
      n_data = 16'h1234; n_valid = 1'b1;
      w_data = 16'h7777; w_valid = 1'b0; w_first = 1'b1; w_last = 1'b1;
      tick();
      n_valid = 1'b0; w_first = 1'b0; w_last = 1'b0;
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.out_south_data !== 16'h1234 || b0.out_south_valid !== 1'b1 ||
          b0.out_east_valid !== 1'b0 || b0.out_east_data !== 16'h7777 ||
          b0.out_east_first !== 1'b1) begin
         n_fail = n_fail + 1;
         $display("FAIL forward got sd=%h sv=%b ev=%b ed=%h ef=%b exp 1234/1/0/7777/1",
                  b0.out_south_data, b0.out_south_valid, b0.out_east_valid,
                  b0.out_east_data, b0.out_east_first);
      end
      tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.out_south_valid !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL forward_drop got sv=%b exp 0", b0.out_south_valid);
      end
      beat(3, 1, 1'b0, 1'b1, 1'b1);
      repeat (5) tick();
   endtask

   task automatic test_overflow();
      rdy0 = 1'b0;
      beat(7, 1, 1'b1, 1'b1, 1'b1);
      beat(8, 1, 1'b1, 1'b1, 1'b1);
      beat(9, 1, 1'b1, 1'b1, 1'b0);
      tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b1 || b0.drain_out_data !== 32'd7 ||
          b0.err_overflow !== 1'b1 || b0.drain_in_ready !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL overflow_hold got v=%b d=%h err=%b rdy=%b exp 1/7/1/0",
                  b0.drain_out_valid, b0.drain_out_data, b0.err_overflow, b0.drain_in_ready);
      end
      tick();
      rdy0 = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.err_overflow !== 1'b1 || b0.drain_out_valid !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL overflow_sticky got err=%b v=%b exp 1/0",
                  b0.err_overflow, b0.drain_out_valid);
      end
      tick();
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.err_overflow !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL overflow_clear got err=%b exp 0", b0.err_overflow);
      end
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      beat(5, 1, 1'b1, 1'b1, 1'b1);
      din_data = 32'd11; din_valid = 1'b1;
      q0.push_back(32'd11);
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_in_ready !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL merge_block got drain_in_ready=%b exp 0", b0.drain_in_ready);
      end
      tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_data !== 32'd5 || b0.drain_in_ready !== 1'b1) begin
         n_fail = n_fail + 1;
         $display("FAIL merge_first got d=%h rdy=%b exp 5/1",
                  b0.drain_out_data, b0.drain_in_ready);
      end
      tick();
      din_valid = 1'b0;
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b1 || b0.drain_out_data !== 32'd11) begin
         n_fail = n_fail + 1;
         $display("FAIL merge_second got v=%b d=%h exp 1/b",
                  b0.drain_out_valid, b0.drain_out_data);
      end
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      rdy0 = 1'b0;
      beat(21, 2, 1'b1, 1'b1, 1'b0);
      repeat (5) tick();
      beat(4, 4, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      macc = 0;
      #1;
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b0 || b0.drain_out_data !== 32'h0 ||
          b0.out_east_data !== 16'h0 || b0.out_east_valid !== 1'b0 ||
          b0.err_overflow !== 1'b0 || bs.drain_out_valid !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_mid got v=%b d=%h ed=%h ev=%b err=%b exp all 0",
                  b0.drain_out_valid, b0.drain_out_data, b0.out_east_data,
                  b0.out_east_valid, b0.err_overflow);
      end
      tick();
      rst = 1'b0;
      rdy0 = 1'b1;
      beat(2, 3, 1'b0, 1'b1, 1'b1);
      tick();
      @(negedge clk);
      n_tests = n_tests + 1;
      if (b0.drain_out_valid !== 1'b1 || b0.drain_out_data !== 32'd6) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_lone_last got v=%b d=%h exp 1/6",
                  b0.drain_out_valid, b0.drain_out_data);
      end
      repeat (5) tick();
   endtask

   initial begin
      w_data = '0; n_data = '0; w_valid = 1'b0; w_first = 1'b0; w_last = 1'b0;
      n_valid = 1'b0; din_data = '0; din_valid = 1'b0; rdy0 = 1'b1; clr0 = 1'b0;
      test_reset();
      test_dot();
      test_sat();
      test_forward();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      repeat (6) tick();
      n_tests = n_tests + 1;
      if (q0.size() != 0 || qs.size() != 0 || qt.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL scoreboard_drain got pending=%0d/%0d/%0d exp 0/0/0",
                  q0.size(), qs.size(), qt.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
